// File: rtl/layout_region_mapper.sv
// Two-stage hit test that maps a screen pixel to a programmable rectangle region.
// Define LAYOUT_SHADOW_EN to stage table writes in a shadow copy committed on frame_start_i.
module layout_region_mapper #(
  parameter  int logic_width_p  = 100,
  parameter  int logic_height_p = 72,
  parameter  int regions_p      = 5,
  parameter  int scale_shift_p  = 3,
  localparam int lx_w   = $clog2(logic_width_p),
  localparam int ly_w   = $clog2(logic_height_p),
  localparam int px_w   = lx_w + scale_shift_p,
  localparam int py_w   = ly_w + scale_shift_p,
  localparam int id_w   = $clog2(regions_p + 1),
  localparam int idx_w  = $clog2(regions_p),
  localparam int rect_w = 2 * lx_w + 2 * ly_w
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 pix_v_i,
  input  logic [px_w-1:0]      pix_x_i,
  input  logic [py_w-1:0]      pix_y_i,
  input  logic                 frame_start_i,
  input  logic                 cfg_we_i,
  input  logic [idx_w-1:0]     cfg_idx_i,
  input  logic [rect_w-1:0]    cfg_rect_i,
  output logic                 region_v_o,
  output logic [id_w-1:0]      region_id_o,
  output logic [lx_w-1:0]      local_x_o,
  output logic [ly_w-1:0]      local_y_o,
  output logic [regions_p-1:0] hit_mask_o
);

  localparam logic [id_w-1:0] no_hit_id  = id_w'(regions_p);
  localparam logic [idx_w:0]  idx_lim    = (idx_w + 1)'(regions_p);
  localparam logic [lx_w:0]   width_lim  = (lx_w + 1)'(logic_width_p);
  localparam logic [ly_w:0]   height_lim = (ly_w + 1)'(logic_height_p);

  // Rect fields are packed {x, y, w, h}; bounds use one extra bit so x+w never wraps.
  function automatic logic rect_hit(input logic [rect_w-1:0] r,
                                    input logic [lx_w-1:0]   cx,
                                    input logic [ly_w-1:0]   cy);
    logic [lx_w-1:0] rx, rw;
    logic [ly_w-1:0] ry, rh;
    {rx, ry, rw, rh} = r;
    return (rw != '0) && (rh != '0) &&
           (cx >= rx) && ({1'b0, cx} < ({1'b0, rx} + {1'b0, rw})) &&
           (cy >= ry) && ({1'b0, cy} < ({1'b0, ry} + {1'b0, rh}));
  endfunction

  function automatic logic [lx_w-1:0] rect_off_x(input logic [rect_w-1:0] r,
                                                 input logic [lx_w-1:0]   cx);
    return cx - r[rect_w-1 -: lx_w];
  endfunction

  function automatic logic [ly_w-1:0] rect_off_y(input logic [rect_w-1:0] r,
                                                 input logic [ly_w-1:0]   cy);
    return cy - r[rect_w-lx_w-1 -: ly_w];
  endfunction

  logic [rect_w-1:0] act_tbl [regions_p];
  logic              cfg_ok;
  logic              unused_bits;

  assign cfg_ok = cfg_we_i && ({1'b0, cfg_idx_i} < idx_lim);

`ifdef LAYOUT_SHADOW_EN
  logic [rect_w-1:0] shd_tbl [regions_p];

  assign unused_bits = ^{pix_x_i[scale_shift_p-1:0], pix_y_i[scale_shift_p-1:0]};

  // A write in a commit cycle lands in both tables so the commit never drops it.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < regions_p; i++) begin
        act_tbl[i] <= '0;
        shd_tbl[i] <= '0;
      end
    end else begin
      for (int i = 0; i < regions_p; i++) begin
        if (frame_start_i) act_tbl[i] <= shd_tbl[i];
        if (cfg_ok && (cfg_idx_i == idx_w'(i))) begin
          shd_tbl[i] <= cfg_rect_i;
          if (frame_start_i) act_tbl[i] <= cfg_rect_i;
        end
      end
    end
  end
`else
  assign unused_bits = ^{pix_x_i[scale_shift_p-1:0], pix_y_i[scale_shift_p-1:0], frame_start_i};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < regions_p; i++) act_tbl[i] <= '0;
    end else begin
      for (int i = 0; i < regions_p; i++)
        if (cfg_ok && (cfg_idx_i == idx_w'(i))) act_tbl[i] <= cfg_rect_i;
    end
  end
`endif

  // Stage 1: pixel -> cell coordinates and range flag
  logic [lx_w-1:0] lx_p0, lx_p1;
  logic [ly_w-1:0] ly_p0, ly_p1;
  logic            oor_p0, oor_p1;
  logic            vld_p1;

  assign lx_p0  = pix_x_i[px_w-1:scale_shift_p];
  assign ly_p0  = pix_y_i[py_w-1:scale_shift_p];
  assign oor_p0 = ({1'b0, lx_p0} >= width_lim) || ({1'b0, ly_p0} >= height_lim);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) vld_p1 <= 1'b0;
    else            vld_p1 <= pix_v_i;
  end

  always_ff @(posedge clk_i) begin
    lx_p1  <= lx_p0;
    ly_p1  <= ly_p0;
    oor_p1 <= oor_p0;
  end

  // Stage 2: parallel compare, lowest-index priority, registered result
  logic [regions_p-1:0] hit_p1;
  logic [id_w-1:0]      win_id_p1;
  logic [lx_w-1:0]      win_lx_p1;
  logic [ly_w-1:0]      win_ly_p1;

  always_comb begin
    hit_p1    = '0;
    win_id_p1 = no_hit_id;
    win_lx_p1 = '0;
    win_ly_p1 = '0;
    for (int i = 0; i < regions_p; i++)
      hit_p1[i] = !oor_p1 && rect_hit(act_tbl[i], lx_p1, ly_p1);
    for (int i = regions_p - 1; i >= 0; i--) begin
      if (hit_p1[i]) begin
        win_id_p1 = id_w'(i);
        win_lx_p1 = rect_off_x(act_tbl[i], lx_p1);
        win_ly_p1 = rect_off_y(act_tbl[i], ly_p1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      region_v_o  <= 1'b0;
      region_id_o <= no_hit_id;
      local_x_o   <= '0;
      local_y_o   <= '0;
      hit_mask_o  <= '0;
    end else begin
      region_v_o <= vld_p1;
      if (vld_p1) begin
        region_id_o <= win_id_p1;
        local_x_o   <= win_lx_p1;
        local_y_o   <= win_ly_p1;
        hit_mask_o  <= hit_p1;
      end
    end
  end

endmodule

// File: tb/tb_layout_region_mapper.sv
// Bench for layout_region_mapper: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an integer model of the region table.
module tb_layout_region_mapper;

  localparam int R = 5;

  logic        clk = 1'b0;
  logic        reset_n_i = 1'b1;
  logic        pix_v_i = 1'b0;
  logic [9:0]  pix_x_i = '0;
  logic [9:0]  pix_y_i = '0;
  logic        frame_start_i = 1'b0;
  logic        cfg_we_i = 1'b0;
  logic [2:0]  cfg_idx_i = '0;
  logic [27:0] cfg_rect_i = '0;
  logic        region_v_o;
  logic [2:0]  region_id_o;
  logic [6:0]  local_x_o;
  logic [6:0]  local_y_o;
  logic [4:0]  hit_mask_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  layout_region_mapper #(
    .logic_width_p (100),
    .logic_height_p(72),
    .regions_p     (5),
    .scale_shift_p (3)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n_i),
    .pix_v_i      (pix_v_i),
    .pix_x_i      (pix_x_i),
    .pix_y_i      (pix_y_i),
    .frame_start_i(frame_start_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_idx_i    (cfg_idx_i),
    .cfg_rect_i   (cfg_rect_i),
    .region_v_o   (region_v_o),
    .region_id_o  (region_id_o),
    .local_x_o    (local_x_o),
    .local_y_o    (local_y_o),
    .hit_mask_o   (hit_mask_o)
  );

  // ---------------- reference model ----------------
  int act_x[R], act_y[R], act_w[R], act_h[R];
  int sh_x[R],  sh_y[R],  sh_w[R],  sh_h[R];
  int pend_v = 0, pend_id = R, pend_lx = 0, pend_ly = 0, pend_mask = 0;
  int eo_v = 0,   eo_id = R,   eo_lx = 0,   eo_ly = 0,   eo_mask = 0;

  function automatic void model_lookup(input int px, input int py,
                                       output int id, output int lx, output int ly,
                                       output int mask);
    int cx, cy;
    cx = px / 8;
    cy = py / 8;
    id = R; lx = 0; ly = 0; mask = 0;
    if (cx >= 100 || cy >= 72) return;
    for (int i = 0; i < R; i++) begin
      if (act_w[i] > 0 && act_h[i] > 0 &&
          cx >= act_x[i] && cx < act_x[i] + act_w[i] &&
          cy >= act_y[i] && cy < act_y[i] + act_h[i]) begin
        mask = mask + (1 << i);
        if (id == R) begin
          id = i;
          lx = cx - act_x[i];
          ly = cy - act_y[i];
        end
      end
    end
  endfunction

  always @(posedge clk) begin
    int rx, ry, rw, rh, idx;
    if (!reset_n_i) begin
      for (int i = 0; i < R; i++) begin
        act_x[i] = 0; act_y[i] = 0; act_w[i] = 0; act_h[i] = 0;
        sh_x[i]  = 0; sh_y[i]  = 0; sh_w[i]  = 0; sh_h[i]  = 0;
      end
      pend_v = 0; pend_id = R; pend_lx = 0; pend_ly = 0; pend_mask = 0;
      eo_v = 0;   eo_id = R;   eo_lx = 0;   eo_ly = 0;   eo_mask = 0;
    end else begin
      eo_v = pend_v;
      if (pend_v != 0) begin
        eo_id = pend_id; eo_lx = pend_lx; eo_ly = pend_ly; eo_mask = pend_mask;
      end
      rx = int'(cfg_rect_i[27:21]);
      ry = int'(cfg_rect_i[20:14]);
      rw = int'(cfg_rect_i[13:7]);
      rh = int'(cfg_rect_i[6:0]);
      idx = int'(cfg_idx_i);
`ifdef LAYOUT_SHADOW_EN
      if (frame_start_i) begin
        for (int i = 0; i < R; i++) begin
          act_x[i] = sh_x[i]; act_y[i] = sh_y[i]; act_w[i] = sh_w[i]; act_h[i] = sh_h[i];
        end
      end
      if (cfg_we_i && idx < R) begin
        sh_x[idx] = rx; sh_y[idx] = ry; sh_w[idx] = rw; sh_h[idx] = rh;
        if (frame_start_i) begin
          act_x[idx] = rx; act_y[idx] = ry; act_w[idx] = rw; act_h[idx] = rh;
        end
      end
`else
      if (cfg_we_i && idx < R) begin
        act_x[idx] = rx; act_y[idx] = ry; act_w[idx] = rw; act_h[idx] = rh;
      end
`endif
      pend_v = pix_v_i ? 1 : 0;
      if (pix_v_i)
        model_lookup(int'(pix_x_i), int'(pix_y_i), pend_id, pend_lx, pend_ly, pend_mask);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    n_tests++;
    if (!reset_n_i) begin
      if (region_v_o !== 1'b0 || region_id_o !== 3'd5 || local_x_o !== 7'd0 ||
          local_y_o !== 7'd0 || hit_mask_o !== 5'd0) begin
        n_fail++;
        $display("FAIL in_reset @%0t: got v=%b id=%0d local=(%0d,%0d) mask=%b, expected v=0 id=5 local=(0,0) mask=00000",
                 $time, region_v_o, region_id_o, local_x_o, local_y_o, hit_mask_o);
      end
    end else if (region_v_o !== (eo_v != 0) || region_id_o !== 3'(eo_id) ||
                 local_x_o !== 7'(eo_lx) || local_y_o !== 7'(eo_ly) ||
                 hit_mask_o !== 5'(eo_mask)) begin
      n_fail++;
      $display("FAIL model_cmp @%0t: got v=%b id=%0d local=(%0d,%0d) mask=%b, expected v=%0d id=%0d local=(%0d,%0d) mask=%05b",
               $time, region_v_o, region_id_o, local_x_o, local_y_o, hit_mask_o,
               eo_v, eo_id, eo_lx, eo_ly, eo_mask[4:0]);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [27:0] pk(input int x, input int y, input int w, input int h);
    return {7'(x), 7'(y), 7'(w), 7'(h)};
  endfunction

  task automatic chk(input string nm, input int id, input int lx, input int ly, input int mask);
    n_tests++;
    if (region_v_o !== 1'b1 || region_id_o !== 3'(id) || local_x_o !== 7'(lx) ||
        local_y_o !== 7'(ly) || hit_mask_o !== 5'(mask)) begin
      n_fail++;
      $display("FAIL %s: got v=%b id=%0d local=(%0d,%0d) mask=%b, expected v=1 id=%0d local=(%0d,%0d) mask=%05b",
               nm, region_v_o, region_id_o, local_x_o, local_y_o, hit_mask_o, id, lx, ly, mask[4:0]);
    end
  endtask

  task automatic chk_idle(input string nm);
    n_tests++;
    if (region_v_o !== 1'b0 || region_id_o !== 3'd5 || local_x_o !== 7'd0 ||
        local_y_o !== 7'd0 || hit_mask_o !== 5'd0) begin
      n_fail++;
      $display("FAIL %s: got v=%b id=%0d local=(%0d,%0d) mask=%b, expected v=0 id=5 local=(0,0) mask=00000",
               nm, region_v_o, region_id_o, local_x_o, local_y_o, hit_mask_o);
    end
  endtask

  task automatic wr(input int idx, input int x, input int y, input int w, input int h);
    cfg_we_i = 1'b1; cfg_idx_i = 3'(idx); cfg_rect_i = pk(x, y, w, h);
    @(negedge clk);
    cfg_we_i = 1'b0;
  endtask

  task automatic commit();
    frame_start_i = 1'b1;
    @(negedge clk);
    frame_start_i = 1'b0;
  endtask

  task automatic look(input string nm, input int px, input int py,
                      input int id, input int lx, input int ly, input int mask);
    pix_v_i = 1'b1; pix_x_i = 10'(px); pix_y_i = 10'(py);
    @(negedge clk);
    pix_v_i = 1'b0;
    @(negedge clk);
    chk(nm, id, lx, ly, mask);
  endtask

  task automatic rand_run(input int n);
    for (int c = 0; c < n; c++) begin
      pix_v_i = ($urandom_range(0, 3) != 0);
      pix_x_i = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 850));
      pix_y_i = ($urandom_range(0, 7) == 0) ? 10'($urandom) : 10'($urandom_range(0, 620));
      cfg_we_i = ($urandom_range(0, 5) == 0);
      cfg_idx_i = 3'($urandom_range(0, 7));
      cfg_rect_i = ($urandom_range(0, 9) == 0) ? 28'($urandom) :
                   pk($urandom_range(0, 110), $urandom_range(0, 80),
                      $urandom_range(0, 50), $urandom_range(0, 40));
      frame_start_i = ($urandom_range(0, 15) == 0);
      @(negedge clk);
    end
    pix_v_i = 1'b0; cfg_we_i = 1'b0; frame_start_i = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    #1 reset_n_i = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset_state");
    #1 reset_n_i = 1'b1;
    @(negedge clk);

    wr(0, 30, 22, 16, 8); commit();
    look("single_hit", 255, 183, 0, 1, 0, 5'b00001);

    wr(1, 20, 20, 20, 20); wr(3, 25, 25, 10, 10); commit();
    look("overlap_priority", 211, 213, 1, 6, 6, 5'b01010);

    wr(4, 59, 4, 32, 64); commit();
    look("right_edge_in", 720, 536, 4, 31, 63, 5'b10000);
    look("right_edge_out", 728, 536, 5, 0, 0, 5'b00000);

    wr(0, 0, 0, 99, 71); commit();
    look("x_out_of_range", 800, 0, 5, 0, 0, 5'b00000);
    look("last_cell_in", 784, 560, 0, 98, 70, 5'b00001);
    wr(3, 0, 60, 10, 60); commit();
    look("y_edge_in", 8, 568, 3, 1, 11, 5'b01000);
    look("y_out_of_range", 8, 576, 5, 0, 0, 5'b00000);

    wr(5, 0, 0, 127, 127); wr(7, 0, 0, 127, 127); commit();
    look("bad_index_ignored", 792, 568, 5, 0, 0, 5'b00000);

    wr(0, 30, 22, 16, 8); commit();
    // write entry 2 in the same cycle a pixel inside it is accepted
    cfg_we_i = 1'b1; cfg_idx_i = 3'd2; cfg_rect_i = pk(95, 0, 4, 4);
    pix_v_i = 1'b1; pix_x_i = 10'(96 * 8); pix_y_i = 10'(8);
    @(negedge clk);
    cfg_we_i = 1'b0; pix_v_i = 1'b0;
    @(negedge clk);
`ifdef LAYOUT_SHADOW_EN
    chk("write_cycle_pixel", 5, 0, 0, 5'b00000);
    look("before_commit", 96 * 8, 8, 5, 0, 0, 5'b00000);
`else
    chk("write_cycle_pixel", 2, 1, 1, 5'b00100);
    look("after_write", 96 * 8, 8, 2, 1, 1, 5'b00100);
`endif
    frame_start_i = 1'b1; pix_v_i = 1'b1;
    @(negedge clk);
    frame_start_i = 1'b0; pix_v_i = 1'b0;
    @(negedge clk);
    chk("commit_cycle_pixel", 2, 1, 1, 5'b00100);

    cfg_we_i = 1'b1; cfg_idx_i = 3'd2; cfg_rect_i = pk(90, 0, 10, 4);
    frame_start_i = 1'b1; pix_v_i = 1'b1; pix_x_i = 10'(91 * 8); pix_y_i = 10'(8);
    @(negedge clk);
    cfg_we_i = 1'b0; frame_start_i = 1'b0; pix_v_i = 1'b0;
    @(negedge clk);
    chk("write_with_commit", 2, 1, 1, 5'b00100);

    rand_run(2500);

    // mid-stream asynchronous reset with pixels flowing
    pix_v_i = 1'b1; pix_x_i = 10'd100; pix_y_i = 10'd100;
    repeat (3) @(negedge clk);
    #2 reset_n_i = 1'b0;
    #1 chk_idle("async_reset_drop");
    @(negedge clk);
    #1 reset_n_i = 1'b1;
    @(negedge clk);
    chk_idle("no_stale_after_reset");
    pix_v_i = 1'b0;
    @(negedge clk);
    look("table_cleared", 255, 183, 5, 0, 0, 5'b00000);

    rand_run(2500);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
